// File: rtl/mem_arbiter.sv
// mem_arbiter: single-owner sequencer for the 8-bit external memory bus.
// Arbitrates IF fetches and MEM loads/stores into byte-serial bus cycles.

module mem_arbiter #(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic        flush,
    output logic        inst_done,
    output logic [31:0] inst_data,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_done,
    output logic [31:0] data_rdata,
    output logic        busy,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);

    typedef enum logic [1:0] {
        IDLE,
        INST_RD,
        DATA_RD,
        DATA_WR
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  len_q, len_d;
    logic [31:0] base_q, base_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] asm_q, asm_d;
    logic        inst_done_q, inst_done_d;
    logic        data_done_q, data_done_d;
    logic [31:0] inst_data_q, inst_data_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;

    logic        inst_ok;
    logic        data_ok;
    logic        pick_data;
    logic [2:0]  cnt_nxt;
    logic [31:0] addr_nxt;
    logic [1:0]  rd_idx;
    logic [1:0]  wr_idx;
    logic [2:0]  req_len;

    // A port is not eligible during its own done cycle.
    assign inst_ok   = inst_req & ~flush & ~inst_done_q;
    assign data_ok   = data_req & ~data_done_q;
    assign pick_data = data_ok & (DATA_FIRST | ~inst_ok);

    assign cnt_nxt  = cnt_q + 3'd1;
    assign addr_nxt = base_q + {29'd0, cnt_nxt};
    assign rd_idx   = cnt_q[1:0] - 2'd1;
    assign wr_idx   = cnt_nxt[1:0];

    // Byte count of a data request from its size code.
    always_comb begin
        req_len = 3'd4;
        unique case (data_size)
            2'd0:    req_len = 3'd1;
            2'd1:    req_len = 3'd2;
            default: req_len = 3'd4;
        endcase
    end

    // Next-state, byte sequencing and output register updates.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        base_d       = base_q;
        wdata_d      = wdata_q;
        asm_d        = asm_q;
        inst_done_d  = 1'b0;
        data_done_d  = 1'b0;
        inst_data_d  = inst_data_q;
        data_rdata_d = data_rdata_q;
        mem_a_d      = mem_a_q;
        mem_dout_d   = mem_dout_q;
        mem_wr_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_data) begin
                    base_d  = data_addr;
                    len_d   = req_len;
                    wdata_d = data_wdata;
                    asm_d   = 32'd0;
                    cnt_d   = 3'd0;
                    mem_a_d = data_addr;
                    if (data_we) begin
                        state_d    = DATA_WR;
                        mem_wr_d   = 1'b1;
                        mem_dout_d = data_wdata[7:0];
                    end else begin
                        state_d = DATA_RD;
                    end
                end else if (inst_ok) begin
                    base_d  = inst_addr;
                    len_d   = 3'd4;
                    asm_d   = 32'd0;
                    cnt_d   = 3'd0;
                    mem_a_d = inst_addr;
                    state_d = INST_RD;
                end
            end
            INST_RD, DATA_RD: begin
                if (state_q == INST_RD && flush) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    // Byte cnt-1 was addressed in the previous cycle.
                    if (cnt_q != 3'd0) begin
                        asm_d[{rd_idx, 3'b000} +: 8] = mem_din;
                    end
                    if (cnt_q == len_q) begin
                        state_d = IDLE;
                        cnt_d   = 3'd0;
                        if (state_q == INST_RD) begin
                            inst_data_d = asm_d;
                            inst_done_d = 1'b1;
                        end else begin
                            data_rdata_d = asm_d;
                            data_done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_nxt;
                        if (cnt_nxt < len_q) begin
                            mem_a_d = addr_nxt;
                        end
                    end
                end
            end
            DATA_WR: begin
                if (cnt_q == len_q - 3'd1) begin
                    state_d     = IDLE;
                    cnt_d       = 3'd0;
                    data_done_d = 1'b1;
                end else begin
                    cnt_d      = cnt_nxt;
                    mem_a_d    = addr_nxt;
                    mem_dout_d = wdata_q[{wr_idx, 3'b000} +: 8];
                    mem_wr_d   = 1'b1;
                end
            end
        endcase
    end

    // State registers; rdy low freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            len_q        <= 3'd0;
            base_q       <= 32'd0;
            wdata_q      <= 32'd0;
            asm_q        <= 32'd0;
            inst_done_q  <= 1'b0;
            data_done_q  <= 1'b0;
            inst_data_q  <= 32'd0;
            data_rdata_q <= 32'd0;
            mem_a_q      <= 32'd0;
            mem_dout_q   <= 8'd0;
            mem_wr_q     <= 1'b0;
        end else if (rdy) begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            base_q       <= base_d;
            wdata_q      <= wdata_d;
            asm_q        <= asm_d;
            inst_done_q  <= inst_done_d;
            data_done_q  <= data_done_d;
            inst_data_q  <= inst_data_d;
            data_rdata_q <= data_rdata_d;
            mem_a_q      <= mem_a_d;
            mem_dout_q   <= mem_dout_d;
            mem_wr_q     <= mem_wr_d;
        end
    end

    assign inst_done  = inst_done_q;
    assign data_done  = data_done_q;
    assign inst_data  = inst_data_q;
    assign data_rdata = data_rdata_q;
    assign mem_a      = mem_a_q;
    assign mem_dout   = mem_dout_q;
    assign mem_wr     = mem_wr_q & rdy;
    assign busy       = (state_q != IDLE);

endmodule
